sys_array_ctrl: RTL

Sequencer for the output-stationary `sysArray` matrix-multiply datapath. It accepts A and B operands as a row-per-beat stream and stores them locally. It then clears the PE accumulators and drives the skewed wavefront onto the array's left (A) and top (B) edges. After the pipeline flushes, it returns the C result one row per beat under valid/ready flow control.

---
 rtl/sys_array_pkg.sv | 24 ++
 rtl/sys_array_skew.sv | 38 +++
 rtl/sys_array_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and width helpers for the systolic-array sequencer.
package sys_array_pkg;

    // Controller phases, in the order a job walks through them.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        FEED,
        FLUSH,
        UNLOAD
    } ctrl_state_t;

    // Width of the wavefront step counter; must hold 0..3N-3 and t+1.
    function automatic int step_w(input int dim);
        return (dim > 0) ? $clog2(3 * dim) : 1;
    endfunction

    // Width of a row/column index; at least one bit so N=1 still elaborates.
    function automatic int idx_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/sys_array_skew.sv
// Skewed edge generator: lane g carries element (t-g) of its row (row mode)
// or column (column mode), and zero outside the matrix.
module sys_array_skew
    import sys_array_pkg::*;
#(
    parameter int n           = 4,
    parameter int matrix_size = 4,
    parameter bit col_mode    = 1'b0
) (
    input  logic [step_w(matrix_size)-1:0]                 t,
    input  logic [matrix_size-1:0][matrix_size-1:0][n-1:0] mat,
    output logic [matrix_size-1:0][n-1:0]                  lane
);

    localparam int TW = step_w(matrix_size);
    localparam int IW = idx_w(matrix_size);

    genvar g;
    generate
        for (g = 0; g < matrix_size; g++) begin : g_lane
            logic [TW:0]   d;
            logic [IW-1:0] k;
            logic          hit;

            // One extra bit so t < g shows up as a set sign bit.
            assign d   = {1'b0, t} - (TW+1)'(g);
            assign hit = !d[TW] && (d < (TW+1)'(matrix_size));
            assign k   = d[IW-1:0];

            if (col_mode) begin : g_col
                assign lane[g] = hit ? mat[k][g] : '0;
            end else begin : g_row
                assign lane[g] = hit ? mat[g][k] : '0;
            end
        end
    endgenerate

endmodule

// File: rtl/sys_array_ctrl.sv
// Sequencer for an output-stationary N x N systolic multiply array:
// loads A/B row by row, clears the PEs, drives the skewed wavefront,
// flushes the PE pipeline and streams C back one row per beat.
module sys_array_ctrl
    import sys_array_pkg::*;
#(
    parameter int n           = 4,
    parameter int matrix_size = 4,
    parameter int pe_lat      = 1
) (
    input  logic                                             clk,
    input  logic                                             nrst,
    input  logic                                             start,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [matrix_size-1:0][n-1:0]                    in_a,
    input  logic [matrix_size-1:0][n-1:0]                    in_b,
    output logic                                             pe_clr,
    output logic                                             pe_en,
    output logic [matrix_size-1:0][n-1:0]                    pe_a_edge,
    output logic [matrix_size-1:0][n-1:0]                    pe_b_edge,
    input  logic [matrix_size-1:0][matrix_size-1:0][2*n-1:0] pe_c,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [matrix_size-1:0][2*n-1:0]                  out_row,
    output logic [idx_w(matrix_size)-1:0]                    out_idx,
    output logic                                             busy,
    output logic                                             done
);

    localparam int TW = step_w(matrix_size);
    localparam int IW = idx_w(matrix_size);
    localparam int FW = (pe_lat > 1) ? $clog2(pe_lat) : 1;

    localparam logic [TW-1:0] LAST_T   = TW'(3 * matrix_size - 3);
    localparam logic [IW-1:0] LAST_IDX = IW'(matrix_size - 1);
    localparam logic [FW-1:0] LAST_FL  = FW'((pe_lat > 0) ? pe_lat - 1 : 0);

    ctrl_state_t state;

    logic [IW-1:0] k;      // load beat
    logic [TW-1:0] t;      // wavefront step
    logic [FW-1:0] fcnt;   // flush cycles elapsed
    logic [IW-1:0] r;      // unload row

    logic [matrix_size-1:0][matrix_size-1:0][n-1:0] mem_a;
    logic [matrix_size-1:0][matrix_size-1:0][n-1:0] mem_b;

    logic [TW-1:0]                t_nxt;
    logic [matrix_size-1:0][n-1:0] skew_a;
    logic [matrix_size-1:0][n-1:0] skew_b;

    // Edges are registered, so compute the step that will be live next cycle:
    // step 0 while in CLEAR, t+1 while in FEED.
    assign t_nxt = (state == FEED) ? t + 1'b1 : t;

    sys_array_skew #(
        .n           (n),
        .matrix_size (matrix_size),
        .col_mode    (1'b0)
    ) u_skew_a (
        .t    (t_nxt),
        .mat  (mem_a),
        .lane (skew_a)
    );

    sys_array_skew #(
        .n           (n),
        .matrix_size (matrix_size),
        .col_mode    (1'b1)
    ) u_skew_b (
        .t    (t_nxt),
        .mat  (mem_b),
        .lane (skew_b)
    );

    // Operand storage; deliberately survives reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid && in_ready) begin
            mem_a[k] <= in_a;
            mem_b[k] <= in_b;
        end
    end

    // Job sequencer with registered control and edge outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            k         <= '0;
            t         <= '0;
            fcnt      <= '0;
            r         <= '0;
            in_ready  <= 1'b0;
            pe_clr    <= 1'b0;
            pe_en     <= 1'b0;
            pe_a_edge <= '0;
            pe_b_edge <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        k        <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (k == LAST_IDX) begin
                            state    <= CLEAR;
                            k        <= '0;
                            in_ready <= 1'b0;
                            pe_clr   <= 1'b1;
                            t        <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state     <= FEED;
                    pe_clr    <= 1'b0;
                    pe_en     <= 1'b1;
                    pe_a_edge <= skew_a;
                    pe_b_edge <= skew_b;
                end
                FEED: begin
                    if (t == LAST_T) begin
                        pe_a_edge <= '0;
                        pe_b_edge <= '0;
                        fcnt      <= '0;
                        if (pe_lat == 0) begin
                            state     <= UNLOAD;
                            pe_en     <= 1'b0;
                            out_valid <= 1'b1;
                            r         <= '0;
                        end else begin
                            state <= FLUSH;
                        end
                    end else begin
                        t         <= t + 1'b1;
                        pe_a_edge <= skew_a;
                        pe_b_edge <= skew_b;
                    end
                end
                FLUSH: begin
                    if (fcnt == LAST_FL) begin
                        state     <= UNLOAD;
                        fcnt      <= '0;
                        pe_en     <= 1'b0;
                        out_valid <= 1'b1;
                        r         <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (r == LAST_IDX) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            r         <= '0;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Accumulators hold during UNLOAD, so the row is read straight off the array.
    always_comb begin
        out_row = '0;
        if (out_valid) begin
            out_row = pe_c[r];
        end
    end

    assign out_idx = r;

    // The last handshake is only known in its own cycle, hence combinational.
    assign done = out_valid && out_ready && (r == LAST_IDX);

endmodule
